// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel coordinate request / colour response bus
interface vga_timing_gen_if #(
    parameter int CW  = 1,
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic [X_W-1:0] x_o;
    logic [Y_W-1:0] y_o;
    logic [CW-1:0]  r_i;
    logic [CW-1:0]  g_i;
    logic [CW-1:0]  b_i;

    modport master (output x_o, y_o, input r_i, g_i, b_i);
    modport slave  (input x_o, y_o, output r_i, g_i, b_i);
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Optional colour-bar source enabled by VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = 1,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pix_en_i,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic               pattern_en_i,
`endif
    vga_timing_gen_if.master   pix,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic [CW-1:0]      r_o,
    output logic [CW-1:0]      g_o,
    output logic [CW-1:0]      b_o,
    output logic               line_start_o,
    output logic               frame_start_o,
    output logic [FRAME_W-1:0] frame_cnt_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
        $error("vga_timing_gen: horizontal widths must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
        $error("vga_timing_gen: vertical widths must be >= 1");
    end
    if (CW < 1 || X_W < 1 || Y_W < 1 || FRAME_W < 1) begin : g_bad_w
        $error("vga_timing_gen: port widths must be >= 1");
    end
    if (longint'(H_TOTAL - 1) >= (longint'(1) << X_W)) begin : g_bad_xw
        $error("vga_timing_gen: X_W too narrow for H_TOTAL");
    end
    if (longint'(V_TOTAL - 1) >= (longint'(1) << Y_W)) begin : g_bad_yw
        $error("vga_timing_gen: Y_W too narrow for V_TOTAL");
    end

    localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0] H_FP_END   = X_W'(H_ACTIVE + H_FP - 1);
    localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE - 1);
    localparam logic [Y_W-1:0] V_FP_END   = Y_W'(V_ACTIVE + V_FP - 1);
    localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);

    localparam logic HS_ON  = (HSYNC_POL != 0);
    localparam logic HS_OFF = ~HS_ON;
    localparam logic VS_ON  = (VSYNC_POL != 0);
    localparam logic VS_OFF = ~VS_ON;

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

    h_state_t           h_q, h_d;
    v_state_t           v_q, v_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [CW-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [CW-1:0]      src_r, src_g, src_b;
    logic               eol;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [2:0] bar;
    always_comb begin
        bar   = 3'((32'(x_q) * 32'd8) / 32'(H_ACTIVE));
        src_r = pattern_en_i ? {CW{bar[2]}} : pix.r_i;
        src_g = pattern_en_i ? {CW{bar[1]}} : pix.g_i;
        src_b = pattern_en_i ? {CW{bar[0]}} : pix.b_i;
    end
`else
    always_comb begin
        src_r = pix.r_i;
        src_g = pix.g_i;
        src_b = pix.b_i;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q           <= HS_ACT;
            v_q           <= VS_ACT;
            x_q           <= '0;
            y_q           <= '0;
            frame_q       <= '0;
            hsync_q       <= HS_OFF;
            vsync_q       <= VS_OFF;
            de_q          <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_q       <= frame_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Everything holds on disabled cycles except the strobes, which drop to 0.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_d       = frame_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        eol           = (x_q == H_LAST);

        if (pix_en_i) begin
            x_d = eol ? '0 : x_q + 1'b1;
            case (h_q)
                HS_ACT:  if (x_q == H_ACT_END)  h_d = HS_FP;
                HS_FP:   if (x_q == H_FP_END)   h_d = HS_SYNC;
                HS_SYNC: if (x_q == H_SYNC_END) h_d = HS_BP;
                HS_BP:   if (eol)               h_d = HS_ACT;
                default:                        h_d = HS_ACT;
            endcase

            if (eol) begin
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
                if (y_q == V_LAST) frame_d = frame_q + 1'b1;
                case (v_q)
                    VS_ACT:  if (y_q == V_ACT_END)  v_d = VS_FP;
                    VS_FP:   if (y_q == V_FP_END)   v_d = VS_SYNC;
                    VS_SYNC: if (y_q == V_SYNC_END) v_d = VS_BP;
                    VS_BP:   if (y_q == V_LAST)     v_d = VS_ACT;
                    default:                        v_d = VS_ACT;
                endcase
            end

            de_d          = (h_q == HS_ACT) && (v_q == VS_ACT);
            hsync_d       = (h_q == HS_SYNC) ? HS_ON : HS_OFF;
            vsync_d       = (v_q == VS_SYNC) ? VS_ON : VS_OFF;
            r_d           = de_d ? src_r : '0;
            g_d           = de_d ? src_g : '0;
            b_d           = de_d ? src_b : '0;
            line_start_d  = (x_q == '0);
            frame_start_d = (x_q == '0) && (y_q == '0);
        end
    end

    assign pix.x_o       = x_q;
    assign pix.y_o       = y_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign r_o           = r_q;
    assign g_o           = g_q;
    assign b_o           = b_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (small raster)
module tb_vga_timing_gen;
    localparam int HA = 6, HF = 2, HS = 3, HB = 1;
    localparam int VA = 3, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    logic pat_en = 1'b0;
    logic hsync, vsync, de, ls, fs;
    logic [CW-1:0] r, g, b;
    logic [1:0] fcnt;

    vga_timing_gen_if #(.CW(CW), .X_W(4), .Y_W(3)) pix_if ();

    logic [3*CW-1:0] lut [HT][VT];
    assign {pix_if.r_i, pix_if.g_i, pix_if.b_i} = lut[pix_if.x_o][pix_if.y_o];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1), .VSYNC_POL(0), .CW(CW), .X_W(4), .Y_W(3), .FRAME_W(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pix_en_i(pix_en),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .pattern_en_i(pat_en),
`endif
        .pix(pix_if),
        .hsync_o(hsync), .vsync_o(vsync), .de_o(de),
        .r_o(r), .g_o(g), .b_o(b),
        .line_start_o(ls), .frame_start_o(fs), .frame_cnt_o(fcnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: t counts enabled pixels since reset; raster position is plain division.
    longint t = 0;
    logic e_hs = 1'b0, e_vs = 1'b1, e_de = 1'b0, e_ls = 1'b0, e_fs = 1'b0;
    logic [3*CW-1:0] e_rgb = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic model_step(input logic rs, input logic en);
        int x, y, bar;
        logic [3*CW-1:0] c;
        if (rs) begin
            t = 0; e_hs = 1'b0; e_vs = 1'b1; e_de = 1'b0;
            e_rgb = '0; e_ls = 1'b0; e_fs = 1'b0;
        end else if (en) begin
            x = int'(t % HT);
            y = int'((t / HT) % VT);
            e_de = (x < HA) && (y < VA);
            e_hs = (x >= HA + HF) && (x <= HA + HF + HS - 1);
            e_vs = !((y >= VA + VF) && (y <= VA + VF + VS - 1));
            c = lut[x][y];
            bar = x * 8 / HA;
`ifdef VGA_TIMING_TEST_PATTERN_EN
            if (pat_en) c = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
`endif
            e_rgb = e_de ? c : '0;
            e_ls = (x == 0);
            e_fs = (x == 0) && (y == 0);
            t++;
        end else begin
            e_ls = 1'b0;
            e_fs = 1'b0;
        end
    endtask

    task automatic step(input logic rs, input logic en);
        rst = rs;
        pix_en = en;
        @(posedge clk);
        #1;
        model_step(rs, en);
    endtask

    task automatic check_all();
        chk("x_o", 32'(pix_if.x_o), 32'(t % HT));
        chk("y_o", 32'(pix_if.y_o), 32'((t / HT) % VT));
        chk("frame_cnt", 32'(fcnt), 32'((t / FT) % 4));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("rgb", 32'({r, g, b}), 32'(e_rgb));
        chk("line_start", 32'(ls), 32'(e_ls));
        chk("frame_start", 32'(fs), 32'(e_fs));
    endtask

    typedef struct {
        logic rs, en;
        int   x, y;
        logic hs, vs, de, ls, fs;
    } vec_t;
    vec_t tbl[16];

    initial begin
        int n_de, n_hs, n_vs, n_ls, n_fs, first_hs;

        foreach (lut[i, j]) lut[i][j] = (3 * CW)'($urandom);

        tbl[0]  = '{1, 1, 0,  0, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 1, 1,  0, 0, 1, 1, 1, 1};
        tbl[2]  = '{0, 0, 1,  0, 0, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 2,  0, 0, 1, 1, 0, 0};
        tbl[4]  = '{0, 1, 3,  0, 0, 1, 1, 0, 0};
        tbl[5]  = '{0, 1, 4,  0, 0, 1, 1, 0, 0};
        tbl[6]  = '{0, 1, 5,  0, 0, 1, 1, 0, 0};
        tbl[7]  = '{0, 1, 6,  0, 0, 1, 1, 0, 0};
        tbl[8]  = '{0, 1, 7,  0, 0, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 8,  0, 0, 1, 0, 0, 0};
        tbl[10] = '{0, 1, 9,  0, 1, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 9,  0, 1, 1, 0, 0, 0};
        tbl[12] = '{0, 1, 10, 0, 1, 1, 0, 0, 0};
        tbl[13] = '{0, 1, 11, 0, 1, 1, 0, 0, 0};
        tbl[14] = '{0, 1, 0,  1, 0, 1, 0, 0, 0};
        tbl[15] = '{0, 1, 1,  1, 0, 1, 1, 1, 0};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rs, tbl[i].en);
            chk($sformatf("tbl%0d.x", i), 32'(pix_if.x_o), 32'(tbl[i].x));
            chk($sformatf("tbl%0d.y", i), 32'(pix_if.y_o), 32'(tbl[i].y));
            chk($sformatf("tbl%0d.hs", i), 32'(hsync), 32'(tbl[i].hs));
            chk($sformatf("tbl%0d.vs", i), 32'(vsync), 32'(tbl[i].vs));
            chk($sformatf("tbl%0d.de", i), 32'(de), 32'(tbl[i].de));
            chk($sformatf("tbl%0d.ls", i), 32'(ls), 32'(tbl[i].ls));
            chk($sformatf("tbl%0d.fs", i), 32'(fs), 32'(tbl[i].fs));
            chk($sformatf("tbl%0d.fcnt", i), 32'(fcnt), 32'd0);
        end

        // One full frame at full rate: region widths and sync placement.
        step(1'b1, 1'b0);
        n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0; first_hs = -1;
        for (int i = 0; i < FT; i++) begin
            step(1'b0, 1'b1);
            n_de += int'(de); n_hs += int'(hsync); n_vs += int'(!vsync);
            n_ls += int'(ls); n_fs += int'(fs);
            if (hsync && first_hs < 0) first_hs = i;
        end
        chk("frame.de_cycles", 32'(n_de), 32'(HA * VA));
        chk("frame.hs_cycles", 32'(n_hs), 32'(HS * VT));
        chk("frame.vs_cycles", 32'(n_vs), 32'(VS * HT));
        chk("frame.ls_pulses", 32'(n_ls), 32'(VT));
        chk("frame.fs_pulses", 32'(n_fs), 32'd1);
        chk("frame.first_hs", 32'(first_hs), 32'(HA + HF));
        chk("frame.fcnt", 32'(fcnt), 32'd1);

        // Half-rate enable: held outputs double, strobes stay single-cycle.
        step(1'b1, 1'b0);
        n_de = 0; n_ls = 0; n_fs = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            step(1'b0, (i % 2) == 0);
            n_de += int'(de); n_ls += int'(ls); n_fs += int'(fs);
            check_all();
        end
        chk("half.de_cycles", 32'(n_de), 32'(2 * HA * VA));
        chk("half.ls_pulses", 32'(n_ls), 32'(VT));
        chk("half.fs_pulses", 32'(n_fs), 32'd1);

        // Frame counter wraps 3 -> 0.
        step(1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            for (int i = 0; i < FT; i++) step(1'b0, 1'b1);
            chk($sformatf("wrap.fcnt%0d", k), 32'(fcnt), 32'(k % 4));
        end

        // Reset mid-frame with a non-zero frame count.
        step(1'b1, 1'b0);
        for (int i = 0; i < FT + 2 * HT + 5; i++) step(1'b0, 1'b1);
        chk("mid.pre_fcnt", 32'(fcnt), 32'd1);
        step(1'b1, 1'b1);
        chk("mid.x", 32'(pix_if.x_o), 32'd0);
        chk("mid.y", 32'(pix_if.y_o), 32'd0);
        chk("mid.de", 32'(de), 32'd0);
        chk("mid.hs", 32'(hsync), 32'd0);
        chk("mid.vs", 32'(vsync), 32'd1);
        chk("mid.fcnt", 32'(fcnt), 32'd0);
        step(1'b0, 1'b0);
        chk("mid.hold_fs", 32'(fs), 32'd0);
        chk("mid.hold_x", 32'(pix_if.x_o), 32'd0);
        step(1'b0, 1'b1);
        chk("mid.fs", 32'(fs), 32'd1);
        chk("mid.ls", 32'(ls), 32'd1);
        chk("mid.fcnt_after", 32'(fcnt), 32'd0);

        // Randomised enable, reset and pattern select against the reference.
        step(1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ((i % 50) == 0) pat_en = 1'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
            check_all();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Replaces the fixed 640x480 horizontal/vertical counter-plus-state-machine pair.
- Produces pixel coordinates for a combinational colour source, samples that source's RGB, and emits registered, mutually aligned hsync/vsync/data-enable/RGB.
- Adds:
  - programmable porch, sync and active widths;
  - sync polarity;
  - a pixel-clock enable;
  - line/frame strobes and a frame counter.

Parameters:
- H_ACTIVE, 640, visible pixels per line (>=1)
- H_FP, 16, horizontal front porch pixels (>=1)
- H_SYNC, 96, hsync pulse pixels (>=1)
- H_BP, 48, horizontal back porch pixels (>=1)
- V_ACTIVE, 480, visible lines per frame (>=1)
- V_FP, 10, vertical front porch lines (>=1)
- V_SYNC, 2, vsync pulse lines (>=1)
- V_BP, 33, vertical back porch lines (>=1)
- HSYNC_POL, 0, hsync asserted level (0 = active-low)
- VSYNC_POL, 0, vsync asserted level (0 = active-low)
- CW, 1, bits per colour channel
- X_W, 10, width of x_o; must hold H_ACTIVE+H_FP+H_SYNC+H_BP-1
- Y_W, 10, width of y_o; must hold V total - 1
- FRAME_W, 8, frame counter width

Ports:
- clk_i, input, 1, system clock
- rst_i, input, 1, synchronous active-high reset
- pix_en_i, input, 1, pixel-clock enable; all state advances only when high
- r_i, input, CW, red for current (x_o, y_o), combinational from x_o/y_o
- g_i, input, CW, green, same timing
- b_i, input, CW, blue, same timing
- x_o, output, X_W, horizontal count 0..H_TOTAL-1
- y_o, output, Y_W, vertical count 0..V_TOTAL-1
- hsync_o, output, 1, registered horizontal sync
- vsync_o, output, 1, registered vertical sync
- de_o, output, 1, registered data enable (active area)
- r_o, output, CW, registered red, zero outside active area
- g_o, output, CW, registered green, zero outside active area
- b_o, output, CW, registered blue, zero outside active area
- line_start_o, output, 1, one-cycle pulse, registered, first pixel of each line
- frame_start_o, output, 1, one-cycle pulse, registered, first pixel of each frame
- frame_cnt_o, output, FRAME_W, frames completed, wraps

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Any width parameter 0 or counter overflow -> elaboration error.
- Horizontal FSM states and transitions, in order:
  - H_ACT (x < H_ACTIVE) -> H_FP -> H_SYNC -> H_BP -> H_ACT.
  - Each transition occurs when x_o reaches the last count of the current region and pix_en_i=1.
- Vertical FSM:
  - States V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT, in the same order.
  - Steps only on a pix_en_i=1 cycle where x_o = H_TOTAL-1 (end of line).
- Wrap and frame counter:
  - x_o wraps H_TOTAL-1 -> 0 and y_o increments.
  - y_o wraps V_TOTAL-1 -> 0 simultaneously with x wrap.
  - frame_cnt_o increments on that same cycle, wrapping 2^FRAME_W-1 -> 0.
- pix_en_i=0: counters, FSMs and all registered outputs hold their values. Strobes stay high only if already high? No — strobes are forced 0 on hold cycles (single pulse per event).
- Output stage (stage 1), registered on pix_en_i=1 from stage-0 counter state:
  - de_o = (x<H_ACTIVE)&&(y<V_ACTIVE).
  - hsync_o = HSYNC_POL when x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HSYNC_POL.
  - vsync_o = VSYNC_POL when y in the V_SYNC region (whole lines, changing at x=0), else ~VSYNC_POL.
  - RGB outputs = de ? inputs : 0.
  - line_start_o = (x==0).
  - frame_start_o = (x==0 && y==0).
- Latency: x_o/y_o to all registered outputs is exactly 1 enabled cycle. Sync, de and RGB are mutually aligned.
- Reset values (rst_i overrides pix_en_i):
  - x_o=0, y_o=0, FSMs H_ACT/V_ACT, frame_cnt_o=0.
  - hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL.
  - de_o=0, RGB=0, strobes=0.
- Reset mid-frame: next cycle is the reset state. The first enabled cycle after release re-presents (0,0). The following enabled cycle shows frame_start_o=1 and line_start_o=1, with frame_cnt_o still 0.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- When defined: extra input pattern_en_i (1 bit).
  - When pattern_en_i=1, stage 1 substitutes 8 vertical colour bars for r_i/g_i/b_i.
  - Bar index = x*8/H_ACTIVE (integer); bit2=R, bit1=G, bit0=B.
  - Each bit is replicated across CW.
  - Bars are still gated by de.
- When undefined: port absent, RGB always from inputs.

Test Plan:
- Defaults, pix_en_i=1, reset released at frame start:
  - hsync_o low for exactly 96 cycles per line, first low 657 cycles after x_o=0;
  - line period 800 cycles;
  - vsync_o low exactly 2 lines starting at line 490;
  - frame period 420000 cycles.
- r_i=g_i=b_i=1 constant -> de_o/RGB high exactly 640x480 = 307200 cycles per frame; RGB never high when de_o=0.
- pix_en_i toggling 1,0,1,0 -> all timings exactly double in clk cycles; outputs stable on enable-low cycles; strobes one cycle wide.
- Small params:
  - Setup: H=4/1/1/1, V=2/1/1/1, HSYNC_POL=1, FRAME_W=2.
  - hsync high only at x=5.
  - frame_cnt_o sequence 0,1,2,3,0 every 35 cycles.
- Assert rst_i at x=300, y=200 for 1 cycle -> next cycle x_o=0, y_o=0, de_o=0, hsync_o=vsync_o=1; frame_start_o=1 one enabled cycle later.
- VGA_TIMING_TEST_PATTERN_EN defined, pattern_en_i=1, CW=1 -> RGB at x=0..79 = 000, x=80..159 = 001, ..., x=560..639 = 111.
